// File: rtl/decode_pkg.sv
// Shared definitions for the instruction-decode stage: opcodes, control
// bundles carried through ID/EX, and the main control decoder.
package decode_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_AW   = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic       reg_dst;
    logic [1:0] alu_op;
    logic       alu_src;
  } ex_ctrl_t;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
  } m_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    ex_ctrl_t ex;
    m_ctrl_t  m;
    wb_ctrl_t wb;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Main control table; unknown opcodes decode to all-zero controls.
  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
    ctrl_t c;
    c = CTRL_NOP;
    case (opcode)
      OP_RTYPE: c = ctrl_t'({4'b1100, 3'b000, 2'b10});
      OP_LW:    c = ctrl_t'({4'b0001, 3'b010, 2'b11});
      OP_SW:    c = ctrl_t'({4'b0001, 3'b001, 2'b00});
      OP_BEQ:   c = ctrl_t'({4'b0010, 3'b100, 2'b00});
      OP_ADDI:  c = ctrl_t'({4'b0001, 3'b000, 2'b10});
      OP_J:     c = CTRL_NOP;
      default:  c = CTRL_NOP;
    endcase
    return c;
  endfunction

  function automatic logic is_legal(input logic [5:0] opcode);
    logic ok;
    ok = 1'b0;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// 32-entry register file, two combinational read ports, one write port.
// r0 reads as zero; with BYPASS a same-cycle write is visible on reads.
// Ports: clk, rst_n; we_i/waddr_i/wdata_i write port;
//        raddr1_i/raddr2_i -> rdata1_c_o/rdata2_c_o (combinational).
module decode_regfile
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_c_o,
  output logic [DATA_W-1:0] rdata2_c_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              wr_en;

  assign wr_en = we_i && (waddr_i != '0);

  // Storage; every entry clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports with optional write-through.
  always_comb begin
    rdata1_c_o = '0;
    rdata2_c_o = '0;
    if (raddr1_i != '0) begin
      if (BYPASS && wr_en && (waddr_i == raddr1_i)) rdata1_c_o = wdata_i;
      else                                          rdata1_c_o = regs_q[raddr1_i];
    end
    if (raddr2_i != '0) begin
      if (BYPASS && wr_en && (waddr_i == raddr2_i)) rdata2_c_o = wdata_i;
      else                                          rdata2_c_o = regs_q[raddr2_i];
    end
  end

endmodule

// File: rtl/decode_pipe.sv
// MIPS R2000 instruction-decode stage: register file, control decode,
// load-use hazard detection and a ready/valid ID/EX register with flush.
// Ports: if_valid/if_ready/pc/inst_in from fetch; wb_* writeback port;
//        flush, ex_ready from execute; ex_valid, rs/rt/rd, imm, data_1/2,
//        pc_branch, ex/m/wb registered ID/EX contents; equal, jump,
//        jump_target, exception combinational.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter bit          SIGN_EXT  = 1'b1,
  parameter bit          BYPASS    = 1'b1,
  parameter bit          HAZARD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [DATA_W-1:0] pc,
  input  logic [31:0]       inst_in,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] data_1,
  output logic [DATA_W-1:0] data_2,
  output logic [DATA_W-1:0] pc_branch,
  output logic [3:0]        ex,
  output logic [2:0]        m,
  output logic [1:0]        wb,
  output logic              equal,
  output logic              jump,
  output logic [DATA_W-1:0] jump_target,
  output logic              exception
);

  logic [5:0]        opcode;
  logic [4:0]        inst_rs, inst_rt, inst_rd;
  ctrl_t             ctrl_dec;
  logic              legal;
  logic [DATA_W-1:0] imm_ext, pc_plus4, branch_tgt;
  logic [DATA_W-1:0] rdata1, rdata2;
  logic              load, hazard, accept;

  logic              ex_valid_q, ex_valid_d;
  logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [DATA_W-1:0] imm_q, imm_d, data1_q, data1_d, data2_q, data2_d;
  logic [DATA_W-1:0] pc_branch_q, pc_branch_d;
  ctrl_t             ctrl_q, ctrl_d;

  assign opcode  = inst_in[31:26];
  assign inst_rs = inst_in[25:21];
  assign inst_rt = inst_in[20:16];
  assign inst_rd = inst_in[15:11];

  decode_regfile #(
    .DATA_W (DATA_W),
    .BYPASS (BYPASS)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (wb_we),
    .waddr_i    (wb_addr),
    .wdata_i    (wb_data),
    .raddr1_i   (inst_rs),
    .raddr2_i   (inst_rt),
    .rdata1_c_o (rdata1),
    .rdata2_c_o (rdata2)
  );

  // Decode, immediate extension and target arithmetic (all modulo 2^DATA_W).
  always_comb begin
    ctrl_dec = decode_ctrl(opcode);
    legal    = is_legal(opcode);
    if (SIGN_EXT) imm_ext = {{(DATA_W-16){inst_in[15]}}, inst_in[15:0]};
    else          imm_ext = {{(DATA_W-16){1'b0}}, inst_in[15:0]};
    pc_plus4    = pc + DATA_W'(4);
    branch_tgt  = pc_plus4 + (imm_ext << 2);
    jump_target = {pc_plus4[DATA_W-1:28], inst_in[25:0], 2'b00};
  end

  // Handshake: stall on a load in EX whose destination the incoming
  // instruction reads; flush always consumes the incoming instruction.
  always_comb begin
    load     = !ex_valid_q || ex_ready;
    hazard   = HAZARD_EN && ex_valid_q && ctrl_q.m.mem_read && (rt_q != '0) && if_valid
               && ((rt_q == inst_rs) || (rt_q == inst_rt));
    if_ready = flush || (load && !hazard);
    accept   = if_valid && if_ready && !flush;
    jump      = accept && (opcode == OP_J);
    exception = accept && !legal;
    equal     = (rdata1 == rdata2);
  end

  // ID/EX next state, in priority: flush, bubble, capture, drain, hold.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    data1_d     = data1_q;
    data2_d     = data2_q;
    pc_branch_d = pc_branch_q;
    ctrl_d      = ctrl_q;
    if (flush || (load && hazard)) begin
      ex_valid_d = 1'b0;
      ctrl_d     = CTRL_NOP;
    end else if (load && if_valid) begin
      ex_valid_d  = 1'b1;
      rs_d        = inst_rs;
      rt_d        = inst_rt;
      rd_d        = inst_rd;
      imm_d       = imm_ext;
      data1_d     = rdata1;
      data2_d     = rdata2;
      pc_branch_d = branch_tgt;
      ctrl_d      = ctrl_dec;
    end else if (load) begin
      ex_valid_d = 1'b0;
    end
  end

  // ID/EX register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      data1_q     <= '0;
      data2_q     <= '0;
      pc_branch_q <= '0;
      ctrl_q      <= CTRL_NOP;
    end else begin
      ex_valid_q  <= ex_valid_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      pc_branch_q <= pc_branch_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign rs        = rs_q;
  assign rt        = rt_q;
  assign rd        = rd_q;
  assign imm       = imm_q;
  assign data_1    = data1_q;
  assign data_2    = data2_q;
  assign pc_branch = pc_branch_q;
  assign ex        = ctrl_q.ex;
  assign m         = ctrl_q.m;
  assign wb        = ctrl_q.wb;

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: instance 0 uses all features on, instance 1 has
// SIGN_EXT/BYPASS/HAZARD_EN off. Both see the same stimulus and are checked
// against a behavioural model each cycle.
module tb_decode_pipe;

  logic        clk;
  logic        rst_n;
  logic        if_valid, wb_we, flush, ex_ready;
  logic [31:0] pc, inst_in, wb_data;
  logic [4:0]  wb_addr;

  logic        if_ready_w [2];
  logic        ex_valid_w [2];
  logic        equal_w    [2];
  logic        jump_w     [2];
  logic        exc_w      [2];
  logic [4:0]  rs_w [2];
  logic [4:0]  rt_w [2];
  logic [4:0]  rd_w [2];
  logic [31:0] imm_w [2];
  logic [31:0] d1_w  [2];
  logic [31:0] d2_w  [2];
  logic [31:0] pcb_w [2];
  logic [31:0] jt_w  [2];
  logic [3:0]  ex_w [2];
  logic [2:0]  m_w  [2];
  logic [1:0]  wb_w [2];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  decode_pipe #(.DATA_W(32), .SIGN_EXT(1'b1), .BYPASS(1'b1), .HAZARD_EN(1'b1)) u_dut_full (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready_w[0]),
    .pc(pc), .inst_in(inst_in), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid_w[0]),
    .rs(rs_w[0]), .rt(rt_w[0]), .rd(rd_w[0]), .imm(imm_w[0]),
    .data_1(d1_w[0]), .data_2(d2_w[0]), .pc_branch(pcb_w[0]),
    .ex(ex_w[0]), .m(m_w[0]), .wb(wb_w[0]), .equal(equal_w[0]), .jump(jump_w[0]),
    .jump_target(jt_w[0]), .exception(exc_w[0])
  );

  decode_pipe #(.DATA_W(32), .SIGN_EXT(1'b0), .BYPASS(1'b0), .HAZARD_EN(1'b0)) u_dut_min (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready_w[1]),
    .pc(pc), .inst_in(inst_in), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid_w[1]),
    .rs(rs_w[1]), .rt(rt_w[1]), .rd(rd_w[1]), .imm(imm_w[1]),
    .data_1(d1_w[1]), .data_2(d2_w[1]), .pc_branch(pcb_w[1]),
    .ex(ex_w[1]), .m(m_w[1]), .wb(wb_w[1]), .equal(equal_w[1]), .jump(jump_w[1]),
    .jump_target(jt_w[1]), .exception(exc_w[1])
  );

  // Behavioural model state, one copy per instance.
  logic [31:0] mregs [2][32];
  logic        mev  [2];
  logic [4:0]  mrs  [2];
  logic [4:0]  mrt  [2];
  logic [4:0]  mrd  [2];
  logic [31:0] mimm [2];
  logic [31:0] md1  [2];
  logic [31:0] md2  [2];
  logic [31:0] mpcb [2];
  logic [3:0]  mex  [2];
  logic [2:0]  mm   [2];
  logic [1:0]  mwb  [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Instance 0 has every option enabled, instance 1 none.
  function automatic bit cfg_on(input int k);
    return k == 0;
  endfunction

  // {legal, ex[3:0], m[2:0], wb[1:0]} straight from the opcode table.
  function automatic logic [9:0] ref_ctrl(input logic [5:0] op);
    case (op)
      6'b000000: return {1'b1, 4'b1100, 3'b000, 2'b10};
      6'b100011: return {1'b1, 4'b0001, 3'b010, 2'b11};
      6'b101011: return {1'b1, 4'b0001, 3'b001, 2'b00};
      6'b000100: return {1'b1, 4'b0010, 3'b100, 2'b00};
      6'b001000: return {1'b1, 4'b0001, 3'b000, 2'b10};
      6'b000010: return {1'b1, 4'b0000, 3'b000, 2'b00};
      default:   return 10'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input int k, input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (cfg_on(k) && wb_we && wb_addr == a) return wb_data;
    return mregs[k][a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 32; r++) mregs[k][r] = 32'd0;
      mev[k] = 1'b0; mrs[k] = '0; mrt[k] = '0; mrd[k] = '0;
      mimm[k] = '0; md1[k] = '0; md2[k] = '0; mpcb[k] = '0;
      mex[k] = '0; mm[k] = '0; mwb[k] = '0;
    end
  endtask

  task automatic check_regs();
    for (int k = 0; k < 2; k++) begin
      string p;
      p = $sformatf("d%0d", k);
      check({p, ".ex_valid"},  ex_valid_w[k], mev[k]);
      check({p, ".rs"},        rs_w[k],  mrs[k]);
      check({p, ".rt"},        rt_w[k],  mrt[k]);
      check({p, ".rd"},        rd_w[k],  mrd[k]);
      check({p, ".imm"},       imm_w[k], mimm[k]);
      check({p, ".data_1"},    d1_w[k],  md1[k]);
      check({p, ".data_2"},    d2_w[k],  md2[k]);
      check({p, ".pc_branch"}, pcb_w[k], mpcb[k]);
      check({p, ".ex"},        ex_w[k],  mex[k]);
      check({p, ".m"},         m_w[k],   mm[k]);
      check({p, ".wb"},        wb_w[k],  mwb[k]);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a_pc, input logic [31:0] ins,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic fl, input logic er);
    if_valid = v; pc = a_pc; inst_in = ins;
    wb_we = we; wb_addr = wa; wb_data = wd;
    flush = fl; ex_ready = er;
  endtask

  // One cycle: check combinational outputs, advance the model, check ID/EX.
  task automatic tick();
    #2;
    for (int k = 0; k < 2; k++) begin
      logic        load, haz, rdy, acc;
      logic [9:0]  c;
      logic [31:0] r1, r2, immx;
      logic [4:0]  irs, irt;
      string       p;
      p    = $sformatf("d%0d", k);
      irs  = inst_in[25:21];
      irt  = inst_in[20:16];
      c    = ref_ctrl(inst_in[31:26]);
      r1   = ref_read(k, irs);
      r2   = ref_read(k, irt);
      immx = (cfg_on(k) && inst_in[15]) ? (32'hFFFF_0000 | 32'(inst_in[15:0])) : 32'(inst_in[15:0]);
      load = !mev[k] || ex_ready;
      haz  = cfg_on(k) && mev[k] && mm[k][1] && (mrt[k] != 5'd0) && if_valid
             && (mrt[k] == irs || mrt[k] == irt);
      rdy  = flush || (load && !haz);
      acc  = if_valid && rdy && !flush;
      check({p, ".if_ready"},    if_ready_w[k], rdy);
      check({p, ".equal"},       equal_w[k], r1 == r2);
      check({p, ".jump"},        jump_w[k], acc && inst_in[31:26] == 6'b000010);
      check({p, ".exception"},   exc_w[k], acc && !c[9]);
      check({p, ".jump_target"}, jt_w[k],
            ((pc + 32'd4) & 32'hF000_0000) | (32'(inst_in[25:0]) * 32'd4));
      if (flush || (load && haz)) begin
        mev[k] = 1'b0; mex[k] = '0; mm[k] = '0; mwb[k] = '0;
      end else if (load && if_valid) begin
        mev[k] = 1'b1; mrs[k] = irs; mrt[k] = irt; mrd[k] = inst_in[15:11];
        mimm[k] = immx; md1[k] = r1; md2[k] = r2;
        mpcb[k] = pc + 32'd4 + immx * 32'd4;
        mex[k] = c[8:5]; mm[k] = c[4:2]; mwb[k] = c[1:0];
      end else if (load) begin
        mev[k] = 1'b0;
      end
      if (wb_we && wb_addr != 5'd0) mregs[k][wb_addr] = wb_data;
    end
    @(posedge clk);
    #1;
    check_regs();
  endtask

  // Asynchronous reset away from any clock edge; outputs must clear at once.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [31:0] LW_2_4_1  = {6'b100011, 5'd1, 5'd2, 16'd4};
  localparam logic [31:0] LW_2_0_1  = {6'b100011, 5'd1, 5'd2, 16'd0};
  localparam logic [31:0] ADD_3_2_4 = {6'b000000, 5'd2, 5'd4, 5'd3, 11'h020};
  localparam logic [31:0] BEQ_5_5_M1 = {6'b000100, 5'd5, 5'd5, 16'hFFFF};
  localparam logic [31:0] ADDI_6_0_7 = {6'b001000, 5'd0, 5'd6, 16'd7};
  localparam logic [31:0] ILLEGAL   = {6'b111111, 26'd0};
  localparam logic [31:0] ADD_R0    = {6'b000000, 5'd0, 5'd0, 5'd7, 11'h020};
  localparam logic [31:0] ADDI_NEG  = {6'b001000, 5'd0, 5'd1, 16'h8000};
  localparam logic [31:0] J_INST    = {6'b000010, 26'h2AB_CDEF};

  initial begin
    logic [5:0] ops [8];
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h23, 6'h3F};
    drive(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #2;
    model_reset();
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;

    // lw $2,4($1) issued straight out of reset.
    drive(1'b1, 32'h100, LW_2_4_1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    tick();
    check("lw.ex_valid", ex_valid_w[0], 1'b1);
    check("lw.ex", ex_w[0], 4'b0001);
    check("lw.m", m_w[0], 3'b010);
    check("lw.wb", wb_w[0], 2'b11);
    check("lw.imm", imm_w[0], 32'd4);
    check("lw.pc_branch", pcb_w[0], 32'h114);

    // Idle, then load-use pair.
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h104, LW_2_0_1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h108, ADD_3_2_4, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    #1;
    check("lu.if_ready_on", if_ready_w[0], 1'b0);
    check("lu.if_ready_off", if_ready_w[1], 1'b1);
    tick();
    check("lu.bubble_on", ex_valid_w[0], 1'b0);
    check("lu.nobubble_off", ex_valid_w[1], 1'b1);
    tick();
    check("lu.issue_valid", ex_valid_w[0], 1'b1);
    check("lu.issue_ex", ex_w[0], 4'b1100);

    // beq $5,$5,-1 while r5 is written back.
    drive(1'b1, 32'h200, BEQ_5_5_M1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b1);
    #1;
    check("beq.equal", equal_w[0], 1'b1);
    tick();
    check("beq.data_1", d1_w[0], 32'hDEAD_BEEF);
    check("beq.data_2", d2_w[0], 32'hDEAD_BEEF);
    check("beq.pc_branch", pcb_w[0], 32'h200);
    check("beq.nobypass", d1_w[1], 32'd0);

    // Back-pressure with flush in the second stalled cycle.
    drive(1'b1, 32'h300, ADDI_6_0_7, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h304, LW_2_4_1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    #1;
    check("bp.if_ready", if_ready_w[0], 1'b0);
    tick();
    check("bp.frozen_pcb", pcb_w[0], 32'h320);
    check("bp.frozen_valid", ex_valid_w[0], 1'b1);
    drive(1'b1, 32'h304, LW_2_4_1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    tick();
    check("bp.flushed", ex_valid_w[0], 1'b0);
    drive(1'b0, 32'h304, LW_2_4_1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    tick();
    check("bp.discarded", ex_valid_w[0], 1'b0);

    // Illegal opcode, r0 write, negative immediate, jump.
    drive(1'b1, 32'h400, ILLEGAL, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    #1;
    check("ill.exception", exc_w[0], 1'b1);
    tick();
    check("ill.ctrl", {ex_w[0], m_w[0], wb_w[0]}, 9'd0);
    drive(1'b1, 32'h404, ADD_R0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    tick();
    check("r0.data_1", d1_w[0], 32'd0);
    drive(1'b1, 32'h408, ADD_R0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    tick();
    check("r0.after", d2_w[0], 32'd0);
    drive(1'b1, 32'h40C, ADDI_NEG, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    tick();
    check("imm.sext", imm_w[0], 32'hFFFF_8000);
    check("imm.zext", imm_w[1], 32'h0000_8000);
    drive(1'b1, 32'hF000_0000, J_INST, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    #1;
    check("j.jump", jump_w[0], 1'b1);
    check("j.target", jt_w[0], 32'hFAAF_37BC);
    tick();

    // Reset during a stall, then immediate accept.
    drive(1'b1, 32'h500, LW_2_0_1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h504, ADD_3_2_4, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    tick();
    do_reset();
    check("rst.ex_valid", ex_valid_w[0], 1'b0);
    check("rst.m", m_w[0], 3'd0);
    drive(1'b1, 32'h600, ADDI_6_0_7, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    tick();
    check("rst.first_accept", ex_valid_w[0], 1'b1);

    // Randomized traffic with small register numbers to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      logic [5:0]  op;
      logic [31:0] ins;
      op = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      drive(1'($urandom_range(0, 3) != 0), $urandom, ins,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) != 0));
      tick();
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
